// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: one shared double-dabble 8-bit binary-to-BCD engine arbitrated among N_REQ requesters.
// Define BCD_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module bcd_convert_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] bin_in,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic [N_REQ-1:0]   done,
    output logic [11:0]        bcd_out
);
    localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nxt;
    logic [7:0] operand;
    logic [11:0] accum, adj;
    logic [3:0] cnt;
    logic [PW-1:0] win;
`ifdef BCD_ARB_ROUND_ROBIN_EN
    logic [PW-1:0] ptr;
`endif
    always_comb begin
        adj[3:0]  = accum[3:0]  > 4'd4 ? accum[3:0]  + 4'd3 : accum[3:0];
        adj[7:4]  = accum[7:4]  > 4'd4 ? accum[7:4]  + 4'd3 : accum[7:4];
        adj[11:8] = accum[11:8] > 4'd4 ? accum[11:8] + 4'd3 : accum[11:8];
    end
    // Later loop iterations overwrite earlier ones, so iterate from lowest to highest priority.
    always_comb begin
        win = '0;
`ifdef BCD_ARB_ROUND_ROBIN_EN
        for (int k = N_REQ; k >= 1; k--)
            if (req[(int'(ptr) + k) % N_REQ]) win = PW'((int'(ptr) + k) % N_REQ);
`else
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[i]) win = PW'(i);
`endif
    end
    always_comb begin
        state_nxt = state == IDLE  ? (|req ? SHIFT : IDLE) :
                    state == SHIFT ? (cnt == 4'd8 ? DONE : SHIFT) : IDLE;
    end
    assign busy = state != IDLE;
    assign done = state == DONE ? grant : '0;
    // Eight shifts at cnt 0..7; the ninth SHIFT edge registers the result on DONE entry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant   <= '0;
            operand <= '0;
            accum   <= '0;
            cnt     <= '0;
            bcd_out <= '0;
`ifdef BCD_ARB_ROUND_ROBIN_EN
            ptr     <= PW'(N_REQ - 1);
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (|req) begin
                    grant   <= N_REQ'(1) << win;
                    operand <= bin_in[8*win +: 8];
                    accum   <= '0;
                    cnt     <= '0;
`ifdef BCD_ARB_ROUND_ROBIN_EN
                    ptr     <= win;
`endif
                end
                SHIFT: if (cnt == 4'd8) bcd_out <= accum;
                else begin
                    {accum, operand} <= {adj[10:0], operand, 1'b0};
                    cnt <= cnt + 4'd1;
                end
                default: grant <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// tb_bcd_convert_arbiter: directed checks of arbitration, latency, conversion and reset abort.
module tb_bcd_convert_arbiter;
    logic clk = 0, reset_n = 0;
    logic [1:0] req = 0, grant, done;
    logic [15:0] bin_in = 0;
    logic busy;
    logic [11:0] bcd_out;
    int n_chk = 0, n_fail = 0;
    bcd_convert_arbiter #(.N_REQ(2)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .bin_in(bin_in),
        .grant(grant), .busy(busy), .done(done), .bcd_out(bcd_out));
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wait_done(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (done == 2'b00 && k < 30);
        chk("done_timeout", k < 30, 1);
    endtask
    task automatic run_one(input int idx, input logic [7:0] v, input logic [11:0] exp, input string tag);
        int k;
        bin_in[8*idx +: 8] = v;
        req = 2'b01 << idx;
        tick();
        chk({tag, "_grant"}, grant, 2'b01 << idx);
        wait_done(k);
        chk({tag, "_latency"}, k, 9);
        chk({tag, "_done"}, done, 2'b01 << idx);
        chk({tag, "_bcd"}, bcd_out, exp);
        req = 0;
        tick();
        chk({tag, "_idle"}, {busy, grant, done}, 0);
    endtask
    initial begin
        int k, seen;
        logic [11:0] ref_bcd;
        tick();
        tick();
        chk("reset_state", {busy, grant, done, bcd_out}, 0);
        reset_n = 1;
        tick();
        chk("idle_no_req", busy, 0);
        run_one(0, 8'd173, 12'h173, "t1_173");
        run_one(0, 8'd0,   12'h000, "sw_0");
        run_one(1, 8'd9,   12'h009, "sw_9");
        run_one(0, 8'd10,  12'h010, "sw_10");
        run_one(1, 8'd99,  12'h099, "sw_99");
        run_one(0, 8'd100, 12'h100, "sw_100");
        run_one(1, 8'd255, 12'h255, "sw_255");
        for (int v = 0; v < 256; v++) begin
            ref_bcd = 12'((v / 100) << 8 | ((v / 10) % 10) << 4 | (v % 10));
            run_one(v % 2, 8'(v), ref_bcd, "exh");
        end
        bin_in = {8'd99, 8'd42};
        req = 2'b11;
        tick();
        chk("both_first_grant", grant, 2'b01);
        wait_done(k);
        chk("both_r0_done", done, 2'b01);
        chk("both_r0_bcd", bcd_out, 12'h042);
        for (int r = 1; r < 4; r++) begin
            wait_done(k);
            chk("both_period", k, 11);
`ifdef BCD_ARB_ROUND_ROBIN_EN
            chk("both_done", done, r % 2 ? 2'b10 : 2'b01);
            chk("both_bcd", bcd_out, r % 2 ? 12'h099 : 12'h042);
`else
            chk("both_done", done, 2'b01);
            chk("both_bcd", bcd_out, 12'h042);
`endif
        end
        req = 0;
        tick();
        tick();
        bin_in = {8'd0, 8'd42};
        req = 2'b01;
        tick();
        chk("t5_grant", grant, 2'b01);
        req = 0;
        bin_in = 0;
        wait_done(k);
        chk("t5_latency", k, 9);
        chk("t5_done", done, 2'b01);
        chk("t5_bcd", bcd_out, 12'h042);
        tick();
        bin_in = {8'd0, 8'd255};
        req = 2'b01;
        tick();
        req = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_busy_before", busy, 1);
        reset_n = 0;
        tick();
        chk("t6_after_reset", {busy, grant, done, bcd_out}, 0);
        reset_n = 1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done != 0 || busy) seen++;
        end
        chk("t6_no_done", seen, 0);
        run_one(1, 8'd77, 12'h077, "t6_recover");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
